// File: rtl/coef_row_fetch_if.sv
// Bundle of command, dual-port ROM and row-stream signals for coef_row_fetch.
// master = sequencer side, slave = environment (command source, ROM, MAC consumer).
interface coef_row_fetch_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [ADDR_WIDTH:0]   num_rows;
  logic                  busy;
  logic                  done;
  logic [ADDR_WIDTH-1:0] rom_addr_1;
  logic [ADDR_WIDTH-1:0] rom_addr_2;
  logic [DATA_WIDTH-1:0] rom_data_1;
  logic [DATA_WIDTH-1:0] rom_data_2;
  logic [DATA_WIDTH-1:0] row_data;
  logic                  row_valid;
  logic                  row_ready;
  logic                  row_last;

  modport master (
    input  start, base_addr, num_rows, rom_data_1, rom_data_2, row_ready,
    output busy, done, rom_addr_1, rom_addr_2, row_data, row_valid, row_last
  );

  modport slave (
    output start, base_addr, num_rows, rom_data_1, rom_data_2, row_ready,
    input  busy, done, rom_addr_1, rom_addr_2, row_data, row_valid, row_last
  );
endinterface

// File: rtl/coef_row_fetch.sv
// Dual-port coefficient ROM read sequencer: issues two rows per cycle under credit
// control, tracks fixed-latency returns and streams rows in address order.
module coef_row_fetch #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 4,
  parameter int ROM_LATENCY = 3,
  parameter int FIFO_DEPTH  = 8
) (
  input logic              clk,
  input logic              rst_n,
  coef_row_fetch_if.master bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int NW = CW + 1;
  localparam int RW = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  state_t state;

  logic [ADDR_WIDTH-1:0] next_addr;
  logic [RW-1:0]         remaining;
  logic [ROM_LATENCY:0]  tag1, tag2, last1, last2;
  logic [CW-1:0]         in_flight, count;
  logic [PW-1:0]         wr_ptr, rd_ptr, wr_ptr2;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] mem_last;

  logic [ADDR_WIDTH-1:0] src_addr;
  logic [RW-1:0]         src_rem;
  logic [1:0]            k;
  logic [NW-1:0]         need, free;
  logic                  issue_req, issue1, issue2, w1, w2, pop;

  // The first pair issues on the same edge that accepts start, so IDLE issues
  // straight from the command inputs instead of the latched registers.
  always_comb begin
    src_addr  = (state == IDLE) ? bus.base_addr : next_addr;
    src_rem   = (state == IDLE) ? bus.num_rows : remaining;
    if (src_rem >= RW'(2))      k = 2'd2;
    else if (src_rem == RW'(1)) k = 2'd1;
    else                        k = 2'd0;
    need      = {1'b0, in_flight} + NW'(k);
    free      = NW'(FIFO_DEPTH) - {1'b0, count};
    issue_req = ((state == IDLE) && bus.start) || (state == ISSUE);
    issue1    = issue_req && (k != 2'd0) && (need <= free);
    issue2    = issue1 && (k == 2'd2);
    w1        = tag1[ROM_LATENCY];
    w2        = tag2[ROM_LATENCY];
    pop       = bus.row_valid && bus.row_ready;
    wr_ptr2   = wr_ptr + PW'(w1);
  end

  assign bus.row_valid = (count != '0);
  assign bus.row_data  = bus.row_valid ? mem[rd_ptr] : '0;
  assign bus.row_last  = bus.row_valid && mem_last[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.rom_addr_1 <= '0;
      bus.rom_addr_2 <= '0;
      next_addr      <= '0;
      remaining      <= '0;
      tag1           <= '0;
      tag2           <= '0;
      last1          <= '0;
      last2          <= '0;
      in_flight      <= '0;
    end else begin
      tag1      <= {tag1[ROM_LATENCY-1:0], issue1};
      tag2      <= {tag2[ROM_LATENCY-1:0], issue2};
      last1     <= {last1[ROM_LATENCY-1:0], issue1 && (src_rem == RW'(1))};
      last2     <= {last2[ROM_LATENCY-1:0], issue2 && (src_rem == RW'(2))};
      in_flight <= in_flight + CW'(issue1) + CW'(issue2) - CW'(w1) - CW'(w2);
      if (issue1) begin
        bus.rom_addr_1 <= src_addr;
        next_addr      <= src_addr + ADDR_WIDTH'(k);
        remaining      <= src_rem - RW'(k);
      end
      if (issue2) bus.rom_addr_2 <= src_addr + ADDR_WIDTH'(1);

      case (state)
        IDLE: begin
          if (bus.start) begin
            if (bus.num_rows == '0) begin
              state    <= DONE;
              bus.done <= 1'b1;
            end else begin
              bus.busy <= 1'b1;
              state    <= (bus.num_rows <= RW'(2)) ? DRAIN : ISSUE;
            end
          end
        end
        ISSUE: if (issue1 && (src_rem == RW'(k))) state <= DRAIN;
        DRAIN: begin
          if (pop && bus.row_last) begin
            state    <= DONE;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
          end
        end
        DONE: begin
          bus.done <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      mem_last <= '0;
    end else begin
      if (w1) mem_last[wr_ptr]  <= last1[ROM_LATENCY];
      if (w2) mem_last[wr_ptr2] <= last2[ROM_LATENCY];
      wr_ptr <= wr_ptr + PW'(w1) + PW'(w2);
      rd_ptr <= rd_ptr + PW'(pop);
      count  <= count + CW'(w1) + CW'(w2) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w1) mem[wr_ptr]  <= bus.rom_data_1;
    if (w2) mem[wr_ptr2] <= bus.rom_data_2;
  end
endmodule
